proc_state_checker: RTL and testbench

//  Parametrised, synthesizable self-checker for the 6502 core. At every instruction

---
 rtl/proc_check_pkg.sv | 46 ++++
 rtl/check_vec_ram.sv | 25 ++
 rtl/proc_state_checker.sv | 192 +++++++++++++++++++
 tb/tb_proc_state_checker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_check_pkg.sv
// Shared types and constants for the 6502 processor state checker.
// The vec_entry_t struct and make_entry helper describe the default geometry
// (5 channels x 8 bits, 16-bit PC); the checker itself slices generically.
package proc_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DONE
  } state_t;

  // Channel indices into the observed-register bus and the care mask
  localparam int unsigned CH_A  = 0;
  localparam int unsigned CH_X  = 1;
  localparam int unsigned CH_Y  = 2;
  localparam int unsigned CH_P  = 3;
  localparam int unsigned CH_S  = 4;
  localparam int unsigned CH_PC = 5;

  localparam int unsigned DEF_NUM_CHAN = 5;
  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_ADDR_W   = 16;

  typedef struct packed {
    logic [DEF_NUM_CHAN:0]                care_mask;
    logic [DEF_ADDR_W-1:0]                exp_pc;
    logic [DEF_NUM_CHAN*DEF_DATA_W-1:0]   exp_obs;
  } vec_entry_t;

  function automatic vec_entry_t make_entry(input logic [DEF_NUM_CHAN:0]              care,
                                            input logic [DEF_ADDR_W-1:0]              epc,
                                            input logic [DEF_NUM_CHAN*DEF_DATA_W-1:0] eobs);
    vec_entry_t e;
    e.care_mask = care;
    e.exp_pc    = epc;
    e.exp_obs   = eobs;
    return e;
  endfunction

  function automatic logic [DEF_DATA_W-1:0] chan_of(input logic [DEF_NUM_CHAN*DEF_DATA_W-1:0] o,
                                                    input int unsigned k);
    return o[k*DEF_DATA_W +: DEF_DATA_W];
  endfunction

endpackage

// File: rtl/check_vec_ram.sv
// Expected-vector table: one write port, one synchronous read port.
module check_vec_ram #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/proc_state_checker.sv
// Sync-driven register/PC checker for the 6502 core. Compares observed state at
// every instruction boundary against a loaded table of masked expected vectors.
// Optional build macro: PROC_CHECK_HALT_ON_FAIL_EN (stop the run at the first
// mismatching vector instead of counting every failure).
module proc_state_checker
  import proc_check_pkg::*;
#(
  parameter int unsigned NUM_CHAN    = DEF_NUM_CHAN,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [$clog2(DEPTH):0]                   num_vec,
  input  logic                                     sync,
  input  logic [ADDR_W-1:0]                        pc,
  input  logic [NUM_CHAN*DATA_W-1:0]               obs,
  input  logic                                     vec_wr_en,
  input  logic [$clog2(DEPTH)-1:0]                 vec_wr_addr,
  input  logic [NUM_CHAN+ADDR_W+NUM_CHAN*DATA_W:0] vec_wr_data,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     pass,
  output logic [$clog2(DEPTH):0]                   fail_count,
  output logic [$clog2(DEPTH)-1:0]                 first_fail_idx,
  output logic [NUM_CHAN:0]                        first_fail_msk,
  output logic                                     timeout,
  output logic                                     overrun
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned OBS_W = NUM_CHAN * DATA_W;
  localparam int unsigned ENT_W = NUM_CHAN + 1 + ADDR_W + OBS_W;
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC + 1);

`ifdef PROC_CHECK_HALT_ON_FAIL_EN
  localparam bit halt_on_fail = 1'b1;
`else
  localparam bit halt_on_fail = 1'b0;
`endif

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   num_vec_q;
  logic [GAP_W-1:0]   gap;
  logic               sync_q;

  logic [ENT_W-1:0]   entry;
  logic [NUM_CHAN:0]  care;
  logic [ADDR_W-1:0]  exp_pc;
  logic [OBS_W-1:0]   exp_obs;
  logic [NUM_CHAN:0]  mis;
  logic               any_mis;
  logic               wr_ok;
  logic               last_cmp;
  logic               gap_expired;
  logic [CNT_W-1:0]   fc_nxt;

  // Table writes are only accepted while no run is in progress
  assign wr_ok = vec_wr_en & ((state == ST_IDLE) | (state == ST_DONE));

  // Read address is idx itself: entry[idx] is ready one clock after idx moves
  check_vec_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .ADDR_W(IDX_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_ok),
    .wr_addr(vec_wr_addr),
    .wr_data(vec_wr_data),
    .rd_addr(idx),
    .rd_data(entry)
  );

  assign care    = entry[ENT_W-1 -: NUM_CHAN+1];
  assign exp_pc  = entry[OBS_W +: ADDR_W];
  assign exp_obs = entry[OBS_W-1:0];

  // Per-channel masked mismatch against the prefetched entry
  always_comb begin
    mis = '0;
    for (int k = 0; k < NUM_CHAN; k++) begin
      mis[k] = care[k] & (obs[k*DATA_W +: DATA_W] != exp_obs[k*DATA_W +: DATA_W]);
    end
    mis[NUM_CHAN] = care[NUM_CHAN] & (pc != exp_pc);
  end

  assign any_mis     = |mis;
  assign last_cmp    = ((CNT_W'(idx) + CNT_W'(1)) == num_vec_q);
  assign gap_expired = (gap == GAP_W'(TIMEOUT_CYC - 1));
  assign fc_nxt      = (any_mis && !(&fail_count)) ? fail_count + CNT_W'(1) : fail_count;

  // Run-control FSM with registered result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      num_vec_q      <= '0;
      gap            <= '0;
      sync_q         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_msk <= '0;
      timeout        <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      // Only syncs seen while armed/running count towards back-to-back detection
      sync_q <= sync & ((state == ST_ARM) | (state == ST_RUN));
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            num_vec_q      <= num_vec;
            idx            <= '0;
            gap            <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_msk <= '0;
            timeout        <= 1'b0;
            overrun        <= 1'b0;
            if (num_vec == '0) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= ST_ARM;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        ST_ARM: begin
          // First sync is the reset-vector fetch: start the gap clock, no compare
          if (sync) begin
            state <= ST_RUN;
            idx   <= '0;
            gap   <= '0;
          end else if (gap_expired) begin
            timeout <= 1'b1;
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
          end else begin
            gap <= gap + GAP_W'(1);
          end
        end
        ST_RUN: begin
          if (sync) begin
            gap <= '0;
            if (sync_q) begin
              // Entry for this sync is not prefetched yet: flag and skip it
              overrun <= 1'b1;
            end else begin
              fail_count <= fc_nxt;
              if (any_mis && (fail_count == '0)) begin
                first_fail_idx <= idx;
                first_fail_msk <= mis;
              end
              idx <= idx + IDX_W'(1);
              if (last_cmp || (halt_on_fail && any_mis)) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (fc_nxt == '0) && !overrun && !timeout;
              end
            end
          end else if (gap_expired) begin
            timeout <= 1'b1;
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
          end else begin
            gap <= gap + GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_state_checker.sv
// Directed bench for proc_state_checker with a result scoreboard.
// Build with PROC_CHECK_HALT_ON_FAIL_EN to exercise the halt-on-fail variant.
module tb_proc_state_checker;
  import proc_check_pkg::*;

`ifdef PROC_CHECK_HALT_ON_FAIL_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [6:0]  num_vec;
  logic        sync;
  logic [15:0] pc;
  logic [39:0] obs;
  logic        vec_wr_en;
  logic [5:0]  vec_wr_addr;
  logic [61:0] vec_wr_data;
  logic        busy, done, pass, timeout, overrun;
  logic [6:0]  fail_count;
  logic [5:0]  first_fail_idx;
  logic [5:0]  first_fail_msk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    bit pass;
    int fc;
    int ffi;
    int ffm;
    bit to;
    bit ov;
  } exp_t;

  exp_t sb[$];

  proc_state_checker dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_vec       (num_vec),
    .sync          (sync),
    .pc            (pc),
    .obs           (obs),
    .vec_wr_en     (vec_wr_en),
    .vec_wr_addr   (vec_wr_addr),
    .vec_wr_data   (vec_wr_data),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail_count    (fail_count),
    .first_fail_idx(first_fail_idx),
    .first_fail_msk(first_fail_msk),
    .timeout       (timeout),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] o5(input logic [7:0] a, input logic [7:0] x,
                                     input logic [7:0] y, input logic [7:0] p,
                                     input logic [7:0] s);
    return {s, p, y, x, a};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic load(input int addr, input logic [5:0] care, input logic [15:0] epc,
                      input logic [39:0] eobs);
    vec_wr_en   = 1'b1;
    vec_wr_addr = 6'(addr);
    vec_wr_data = make_entry(care, epc, eobs);
    cyc();
    vec_wr_en   = 1'b0;
  endtask

  task automatic start_run(input int n);
    num_vec = 7'(n);
    start   = 1'b1;
    cyc();
    start   = 1'b0;
  endtask

  task automatic pulse_sync(input logic [15:0] pcv, input logic [39:0] ov);
    sync = 1'b1;
    pc   = pcv;
    obs  = ov;
    cyc();
    sync = 1'b0;
  endtask

  task automatic push_exp(input bit p, input int fc, input int ffi, input int ffm,
                          input bit to, input bit ov);
    exp_t e;
    e.pass = p; e.fc = fc; e.ffi = ffi; e.ffm = ffm; e.to = to; e.ov = ov;
    sb.push_back(e);
  endtask

  // Bounded wait for done, then compare all result outputs with the next expectation
  task automatic finish_run(input string tag);
    exp_t e;
    int   t = 0;
    while (!done && t < 300) begin
      cyc();
      t++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    e = sb.pop_front();
    check({tag, " pass"},    32'(pass),           32'(e.pass));
    check({tag, " fcount"},  32'(fail_count),     32'(e.fc));
    check({tag, " ff_idx"},  32'(first_fail_idx), 32'(e.ffi));
    check({tag, " ff_msk"},  32'(first_fail_msk), 32'(e.ffm));
    check({tag, " timeout"}, 32'(timeout),        32'(e.to));
    check({tag, " overrun"}, 32'(overrun),        32'(e.ov));
    check({tag, " busy"},    32'(busy),           32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_vec = '0; sync = 1'b0; pc = '0; obs = '0;
    vec_wr_en = 1'b0; vec_wr_addr = '0; vec_wr_data = '0;
    idle(2);
    check("rst busy",    32'(busy),       32'd0);
    check("rst done",    32'(done),       32'd0);
    check("rst pass",    32'(pass),       32'd0);
    check("rst fcount",  32'(fail_count), 32'd0);
    check("rst timeout", 32'(timeout),    32'd0);
    check("rst overrun", 32'(overrun),    32'd0);
    reset = 1'b0;
    cyc();

    // 1: three matching vectors, care=A; entry 2 written in the start cycle
    load(0, 6'b000001, 16'hC000, o5(8'h01, 0, 0, 0, 0));
    load(1, 6'b000001, 16'hC001, o5(8'h02, 0, 0, 0, 0));
    vec_wr_en = 1'b1; vec_wr_addr = 6'd2;
    vec_wr_data = make_entry(6'b000001, 16'hC002, o5(8'h03, 0, 0, 0, 0));
    start_run(3);
    vec_wr_en = 1'b0;
    check("t1 busy", 32'(busy), 32'd1);
    push_exp(1'b1, 0, 0, 0, 1'b0, 1'b0);
    idle(3); pulse_sync(16'hFFFC, o5(8'hAA, 0, 0, 0, 0));
    // Write while busy must be ignored
    load(2, 6'b000001, 16'hC002, o5(8'h99, 0, 0, 0, 0));
    idle(2); pulse_sync(16'hC000, o5(8'h01, 8'h10, 0, 0, 0));
    idle(3); pulse_sync(16'hC001, o5(8'h02, 8'h20, 0, 0, 0));
    idle(3); pulse_sync(16'hC002, o5(8'h03, 8'h30, 0, 0, 0));
    finish_run("t1");

    // 2: vector 1 observes A=0x7F
    start_run(3);
    push_exp(1'b0, 1, 1, 1, 1'b0, 1'b0);
    idle(3); pulse_sync(16'hFFFC, o5(0, 0, 0, 0, 0));
    idle(3); pulse_sync(16'hC000, o5(8'h01, 0, 0, 0, 0));
    idle(3); pulse_sync(16'hC001, o5(8'h7F, 0, 0, 0, 0));
    idle(3); pulse_sync(16'hC002, o5(8'h03, 0, 0, 0, 0));
    finish_run("t2");

    // 3: care=P with wrong X ignored; then PC-only care with wrong PC
    load(0, 6'b001000, 16'hC000, o5(0, 8'h55, 0, 8'h24, 0));
    load(1, 6'b100000, 16'hC002, o5(0, 0, 0, 0, 0));
    start_run(1);
    check("t3 clr fcount", 32'(fail_count), 32'd0);
    check("t3 clr done",   32'(done),       32'd0);
    push_exp(1'b1, 0, 0, 0, 1'b0, 1'b0);
    idle(3); pulse_sync(16'hFFFC, o5(0, 0, 0, 0, 0));
    idle(3); pulse_sync(16'h1234, o5(8'h77, 8'h11, 8'h66, 8'h24, 8'hFD));
    finish_run("t3a");
    start_run(2);
    push_exp(1'b0, 1, 1, 6'b100000, 1'b0, 1'b0);
    idle(3); pulse_sync(16'hFFFC, o5(0, 0, 0, 0, 0));
    idle(3); pulse_sync(16'h1234, o5(8'h77, 8'h11, 8'h66, 8'h24, 8'hFD));
    idle(3); pulse_sync(16'hC003, o5(0, 0, 0, 0, 0));
    finish_run("t3b");

    // 4: syncs stop after vector 0; timeout after 64 sync-free cycles
    load(0, 6'b000001, 16'hC000, o5(8'h01, 0, 0, 0, 0));
    load(1, 6'b000001, 16'hC001, o5(8'h02, 0, 0, 0, 0));
    load(2, 6'b000001, 16'hC002, o5(8'h03, 0, 0, 0, 0));
    start_run(3);
    push_exp(1'b0, 0, 0, 0, 1'b1, 1'b0);
    idle(3); pulse_sync(16'hFFFC, o5(0, 0, 0, 0, 0));
    idle(3); pulse_sync(16'hC000, o5(8'h01, 0, 0, 0, 0));
    idle(63);
    check("t4 timeout@63", 32'(timeout), 32'd0);
    check("t4 done@63",    32'(done),    32'd0);
    idle(1);
    check("t4 timeout@64", 32'(timeout), 32'd1);
    finish_run("t4");

    // 5: back-to-back sync is skipped; idx holds so the run still matches
    start_run(3);
    push_exp(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle(3); pulse_sync(16'hFFFC, o5(0, 0, 0, 0, 0));
    idle(3); pulse_sync(16'hC000, o5(8'h01, 0, 0, 0, 0));
    pulse_sync(16'hC0EE, o5(8'hEE, 0, 0, 0, 0));
    check("t5 overrun", 32'(overrun), 32'd1);
    check("t5 fcount",  32'(fail_count), 32'd0);
    idle(3); pulse_sync(16'hC001, o5(8'h02, 0, 0, 0, 0));
    idle(3); pulse_sync(16'hC002, o5(8'h03, 0, 0, 0, 0));
    finish_run("t5");
    start_run(0);
    check("t5 nv0 done", 32'(done), 32'd1);
    push_exp(1'b1, 0, 0, 0, 1'b0, 1'b0);
    finish_run("t5 nv0");

    // 6: reset mid-run clears results and stops comparing
    start_run(3);
    idle(3); pulse_sync(16'hFFFC, o5(0, 0, 0, 0, 0));
    idle(3); pulse_sync(16'hC000, o5(8'h42, 0, 0, 0, 0));
    check("t6 fcount pre", 32'(fail_count), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t6 rst busy",   32'(busy),       32'd0);
    check("t6 rst done",   32'(done),       32'd0);
    check("t6 rst fcount", 32'(fail_count), 32'd0);
    idle(3); pulse_sync(16'hC001, o5(8'h42, 0, 0, 0, 0));
    idle(2);
    check("t6 idle fcount", 32'(fail_count), 32'd0);
    check("t6 idle busy",   32'(busy),       32'd0);

    // 6b: vectors 0 and 1 fail; halt build stops after vector 0
    start_run(3);
    push_exp(1'b0, HALT ? 1 : 2, 0, 1, 1'b0, 1'b0);
    idle(3); pulse_sync(16'hFFFC, o5(0, 0, 0, 0, 0));
    idle(3); pulse_sync(16'hC000, o5(8'h50, 0, 0, 0, 0));
    check("t6b early done", 32'(done), 32'(HALT));
    idle(3); pulse_sync(16'hC001, o5(8'h51, 0, 0, 0, 0));
    idle(3); pulse_sync(16'hC002, o5(8'h03, 0, 0, 0, 0));
    finish_run("t6b");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
